// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: next-PC select encoding, sequencer
// states and default reset/exception addresses.
package pc_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Word offset to byte offset, sign-extended to the full address width.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/ready channel and decode valid/ready channel of
// the fetch stage; master is the fetch unit, slave is memory plus decode.
interface pc_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ready, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ready, imem_rdata, instr_ready
  );

endinterface

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational next-PC selection from the external PC+4 result and the
// branch/jump information supplied by decode.
module next_pc_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  pc_src_e     pc_src,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  always_comb begin
    // NOTE: default first so every path assigns next_pc and no latch is inferred.
    next_pc = pc_plus4;
    unique case (pc_src)
      PC_SEQ:    next_pc = pc_plus4;
      PC_BRANCH: if (branch_taken) next_pc = pc_plus4 + branch_offset(branch_imm);
      PC_JUMP:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      PC_JR:     next_pc = jr_target & ~32'h0000_0003;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC register and request sequencer: issues one fetch at a time,
// holds the word for decode, and redirects to the exception vector on flush.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  pc_src_e     pc_src,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        flush,
  pc_fetch_unit_if.master bus
);

  fetch_state_e state;
  logic         kill;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic [31:0]  next_pc;
  logic         accept;
  logic         req_outstanding;

  next_pc_sel u_next_pc_sel (
    .pc_plus4     (pc_plus4),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump_index   (jump_index),
    .jr_target    (jr_target),
    .next_pc      (next_pc)
  );

  assign accept          = (state == HOLD) && instr_valid && bus.instr_ready;
  // A request that memory has not answered this cycle cannot be withdrawn.
  assign req_outstanding = (state == FETCH) && imem_req && !bus.imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= 32'h0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
    end else if (flush && !kill) begin
      // NOTE: non-blocking assignments keep every register update in this
      // block order-independent within the clock edge.
      pc          <= EXC_VECTOR;
      instr_valid <= 1'b0;
      if (req_outstanding) begin
        kill <= 1'b1;
      end else begin
        state     <= FETCH;
        imem_req  <= 1'b1;
        imem_addr <= EXC_VECTOR;
      end
    end else begin
      case (state)
        IDLE: begin
          state     <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        FETCH: begin
          if (!imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end else if (bus.imem_ready) begin
            imem_req <= 1'b0;
            if (kill) begin
              // Response to the aborted request is dropped; pc already
              // holds the exception vector for the refetch.
              kill <= 1'b0;
            end else begin
              instr       <= bus.imem_rdata;
              instr_pc    <= imem_addr;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            state       <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = imem_addr;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;

endmodule
